sha256_multiblock_core: RTL and testbench

Parametrised SHA-256 compression engine with multi-block message chaining, a valid/ready block input, and a configurable number of rounds per clock. Host-side padding logic supplies pre-padded 512-bit blocks; this core chains the intermediate hash H0..H7 across blocks and emits one digest per message. It is the throughput-scalable successor of the fixed 8-rounds-per-cycle single-block core.

---
 rtl/sha256_pkg.sv | 55 +++++
 rtl/sha256_rounds_n.sv | 33 +++
 rtl/sha256_multiblock_core.sv | 158 +++++++++++++++
 tb/tb_sha256_multiblock_core.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and round/schedule helper functions.
package sha256_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_UPD} state_t;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [255:0] IV_256 = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [255:0] IV_224 = {
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha256_rounds_n.sv
// Combinational unfold of RPC SHA-256 rounds; word j of i_w/i_k sits at bits [32*j +: 32].
module sha256_rounds_n
   import sha256_pkg::*;
#(
   parameter int RPC = 8
) (
   input  logic [255:0]      i_state,
   input  logic [32*RPC-1:0] i_w,
   input  logic [32*RPC-1:0] i_k,
   output logic [255:0]      o_state
);

   always_comb begin
      logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h, w_t1, w_t2;
      {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_state;
      w_t1 = '0;
      w_t2 = '0;
      for (int j = 0; j < RPC; j++) begin
         w_t1 = w_h + bsig1(w_e) + ch(w_e, w_f, w_g) + i_k[32*j +: 32] + i_w[32*j +: 32];
         w_t2 = bsig0(w_a) + maj(w_a, w_b, w_c);
         w_h  = w_g;
         w_g  = w_f;
         w_f  = w_e;
         w_e  = w_d + w_t1;
         w_d  = w_c;
         w_c  = w_b;
         w_b  = w_a;
         w_a  = w_t1 + w_t2;
      end
      o_state = {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h};
   end

endmodule

// File: rtl/sha256_multiblock_core.sv
// Multi-block SHA-256 engine, RPC rounds per clock, chaining H across blocks of one message.
// Define SHA224_EN to add the mode_224 input and the SHA-224 IV / truncated digest.
module sha256_multiblock_core
   import sha256_pkg::*;
#(
   parameter int RPC = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         blk_valid,
   output logic         blk_ready,
   input  logic [511:0] blk_data,
   input  logic         blk_first,
   input  logic         blk_last,
   input  logic         abort,
`ifdef SHA224_EN
   input  logic         mode_224,
`endif
   output logic [255:0] digest,
   output logic         digest_valid,
   output logic         busy
);

   localparam int NCYC = 64 / RPC;

   if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_bad_rpc
      $error("sha256_multiblock_core: RPC must be 1, 2, 4, 8 or 16");
   end

   state_t            r_state, w_next;
   logic [5:0]        r_cnt;
   logic [31:0]       r_w [0:15];
   logic [31:0]       w_wnext [0:15];
   logic [255:0]      r_work, r_h, r_digest;
   logic              r_dv, r_open, r_last;
   logic              w_accept, w_new_chain, w_cnt_end;
   logic [255:0]      w_iv, w_work_nxt, w_h_sum, w_dig;
   logic [32*RPC-1:0] w_wv, w_kv;

`ifdef SHA224_EN
   logic r_mode;
   assign w_iv  = mode_224 ? IV_224 : IV_256;
   assign w_dig = r_mode ? {w_h_sum[255:32], 32'h0} : w_h_sum;
`else
   assign w_iv  = IV_256;
   assign w_dig = w_h_sum;
`endif

   assign w_new_chain = blk_first || !r_open;
   assign w_cnt_end   = (r_cnt == 6'(NCYC - 1));
   assign digest      = r_digest;
   assign digest_valid = r_dv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_next = ST_RUN;
         ST_RUN:  if (abort) w_next = ST_IDLE;
                  else if (w_cnt_end) w_next = ST_UPD;
         ST_UPD:  w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // abort masks ready so an abort cycle can never also accept a block
   always_comb begin
      blk_ready = (r_state == ST_IDLE) && !abort;
      busy      = (r_state != ST_IDLE);
      w_accept  = blk_valid && blk_ready;
   end

   // Window slides RPC words per cycle; ext[16+k] is schedule word t+16+k.
   always_comb begin
      logic [31:0] w_ext [0:15+RPC];
      logic [5:0]  w_kidx;
      w_wv   = '0;
      w_kv   = '0;
      w_kidx = '0;
      for (int i = 0; i < 16; i++) w_ext[i] = r_w[i];
      for (int i = 16; i < 16 + RPC; i++)
         w_ext[i] = ssig1(w_ext[i-2]) + w_ext[i-7] + ssig0(w_ext[i-15]) + w_ext[i-16];
      for (int i = 0; i < 16; i++) w_wnext[i] = w_ext[i+RPC];
      for (int j = 0; j < RPC; j++) begin
         w_kidx           = 6'(int'(r_cnt) * RPC + j);
         w_wv[32*j +: 32] = r_w[j];
         w_kv[32*j +: 32] = K[w_kidx];
      end
   end

   always_comb begin
      for (int i = 0; i < 8; i++)
         w_h_sum[255-32*i -: 32] = r_h[255-32*i -: 32] + r_work[255-32*i -: 32];
   end

   sha256_rounds_n #(.RPC(RPC)) u_rounds (
      .i_state (r_work),
      .i_w     (w_wv),
      .i_k     (w_kv),
      .o_state (w_work_nxt)
   );

   always_ff @(posedge clk) begin
      if (w_accept) begin
         for (int i = 0; i < 16; i++) r_w[i] <= blk_data[511-32*i -: 32];
         r_work <= w_new_chain ? w_iv : r_h;
      end else if (r_state == ST_RUN) begin
         for (int i = 0; i < 16; i++) r_w[i] <= w_wnext[i];
         r_work <= w_work_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_open   <= 1'b0;
         r_last   <= 1'b0;
         r_dv     <= 1'b0;
         r_h      <= '0;
         r_digest <= '0;
`ifdef SHA224_EN
         r_mode   <= 1'b0;
`endif
      end else begin
         r_dv <= 1'b0;
         if (abort) r_open <= 1'b0;
         case (r_state)
            ST_IDLE: if (w_accept) begin
               r_cnt  <= '0;
               r_last <= blk_last;
               if (w_new_chain) begin
                  r_h <= w_iv;
`ifdef SHA224_EN
                  r_mode <= mode_224;
`endif
               end
            end
            ST_RUN: r_cnt <= r_cnt + 1'b1;
            ST_UPD: if (!abort) begin
               r_h <= w_h_sum;
               if (r_last) begin
                  r_digest <= w_dig;
                  r_dv     <= 1'b1;
                  r_open   <= 1'b0;
               end else begin
                  r_open <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_multiblock_core.sv
// Bench: two cores (RPC=1 and RPC=8) driven independently and checked every cycle
// against a whole-block SHA-256 model with a busy countdown per core.
module tb_sha256_multiblock_core;

   localparam int ND = 2;

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

   localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
   localparam logic [511:0] B_M2A   = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] B_M2B   = {480'h0, 32'h000001c0};

   localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] D_M2    = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
   localparam logic [255:0] D_224   = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         blk_valid [ND];
   logic         blk_ready [ND];
   logic [511:0] blk_data [ND];
   logic         blk_first [ND];
   logic         blk_last [ND];
   logic         abort [ND];
   logic         mode_224 [ND];
   logic [255:0] digest [ND];
   logic         digest_valid [ND];
   logic         busy [ND];
   logic         tmo [ND];

   // model state per core
   int           m_rem [ND];
   logic         m_open [ND];
   logic         m_last [ND];
   logic         m_mode [ND];
   logic         m_dv [ND];
   logic         m_acc [ND];
   logic [255:0] m_h [ND];
   logic [255:0] m_hnext [ND];
   logic [255:0] m_dig [ND];

   int n_err = 0;
   int n_chk = 0;
   int cyc = 0;
   logic [255:0] tmp;

   always #5 clk = ~clk;

   sha256_multiblock_core #(.RPC(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid[0]), .blk_ready(blk_ready[0]),
      .blk_data(blk_data[0]), .blk_first(blk_first[0]), .blk_last(blk_last[0]), .abort(abort[0]),
`ifdef SHA224_EN
      .mode_224(mode_224[0]),
`endif
      .digest(digest[0]), .digest_valid(digest_valid[0]), .busy(busy[0])
   );

   sha256_multiblock_core #(.RPC(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .blk_valid(blk_valid[1]), .blk_ready(blk_ready[1]),
      .blk_data(blk_data[1]), .blk_first(blk_first[1]), .blk_last(blk_last[1]), .abort(abort[1]),
`ifdef SHA224_EN
      .mode_224(mode_224[1]),
`endif
      .digest(digest[1]), .digest_valid(digest_valid[1]), .busy(busy[1])
   );

   function automatic int rpc_of(input int d);
      return (d == 0) ? 1 : 8;
   endfunction

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      logic [63:0] y;
      y = {x, x} >> n;
      return y[31:0];
   endfunction

   // Full 64-round compression of one block plus the feed-forward add.
   function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0]  w [64];
      logic [31:0]  v [8];
      logic [31:0]  t1, t2;
      logic [255:0] res;
      for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
      for (int t = 16; t < 64; t++)
         w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
              + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
            + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
         t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) res[255-32*i -: 32] = v[i] + hin[255-32*i -: 32];
      return res;
   endfunction

   task chk(input string nm, input int d, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s core%0d cyc%0d: actual %h required %h", nm, d, cyc, act, exp);
      end
   endtask

   task automatic model_reset(input int d);
      m_rem[d] = 0; m_open[d] = 1'b0; m_last[d] = 1'b0; m_mode[d] = 1'b0;
      m_dv[d] = 1'b0; m_acc[d] = 1'b0; m_h[d] = '0; m_hnext[d] = '0; m_dig[d] = '0;
   endtask

   // Advance one core across the coming clock edge, using the inputs now applied.
   task automatic model_step(input int d);
      logic         newc;
      logic [255:0] base;
      m_acc[d] = 1'b0;
      m_dv[d]  = 1'b0;
      if (m_rem[d] > 0) begin
         if (abort[d]) begin
            m_rem[d]  = 0;
            m_open[d] = 1'b0;
         end else if (m_rem[d] == 1) begin
            m_rem[d] = 0;
            m_h[d]   = m_hnext[d];
            if (m_last[d]) begin
               m_dig[d]  = m_mode[d] ? {m_hnext[d][255:32], 32'h0} : m_hnext[d];
               m_dv[d]   = 1'b1;
               m_open[d] = 1'b0;
            end else begin
               m_open[d] = 1'b1;
            end
         end else begin
            m_rem[d] = m_rem[d] - 1;
         end
      end else if (abort[d]) begin
         m_open[d] = 1'b0;
      end else if (blk_valid[d]) begin
         m_acc[d] = 1'b1;
         newc = blk_first[d] || !m_open[d];
`ifdef SHA224_EN
         if (newc) m_mode[d] = mode_224[d];
`endif
         base = newc ? (m_mode[d] ? IV224 : IV256) : m_h[d];
         m_hnext[d] = compress(base, blk_data[d]);
         m_last[d]  = blk_last[d];
         m_rem[d]   = 64 / rpc_of(d) + 1;
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (cyc == 2) begin
         chk("model_abc", 0, compress(IV256, B_ABC), D_ABC);
         chk("model_empty", 0, compress(IV256, B_EMPTY), D_EMPTY);
         chk("model_2blk", 0, compress(compress(IV256, B_M2A), B_M2B), D_M2);
`ifdef SHA224_EN
         tmp = compress(IV224, B_ABC);
         chk("model_224", 0, {tmp[255:32], 32'h0}, D_224);
`endif
      end
      for (int d = 0; d < ND; d++) begin
         if (!rst_n) model_reset(d);
         chk("blk_ready", d, 256'(blk_ready[d]), 256'((m_rem[d] == 0) && !abort[d]));
         chk("busy", d, 256'(busy[d]), 256'(m_rem[d] > 0));
         chk("digest_valid", d, 256'(digest_valid[d]), 256'(m_dv[d]));
         chk("digest", d, digest[d], m_dig[d]);
         chk("accept_timeout", d, 256'(tmo[d]), 256'(0));
         if (rst_n) model_step(d);
      end
   end

   task automatic send(input int d, input logic [511:0] data, input logic first, input logic last);
      blk_data[d]  = data;
      blk_first[d] = first;
      blk_last[d]  = last;
      blk_valid[d] = 1'b1;
      for (int k = 0; k < 300; k++) begin
         @(posedge clk); #2;
         if (m_acc[d]) return;
      end
      tmo[d] = 1'b1;
   endtask

   task automatic drain(input int d);
      blk_valid[d] = 1'b0;
      for (int k = 0; k < 200 && m_rem[d] != 0; k++) begin
         @(posedge clk); #2;
      end
      repeat (2) begin @(posedge clk); #2; end
   endtask

   task automatic directed(input int d);
      send(d, B_ABC, 1'b1, 1'b1);
      drain(d);
      send(d, B_EMPTY, 1'b1, 1'b1);
      drain(d);
      send(d, B_M2A, 1'b1, 1'b0);
      send(d, B_M2B, 1'b0, 1'b1);
      drain(d);
      send(d, B_M2A, 1'b1, 1'b0);
      blk_valid[d] = 1'b0;
      @(posedge clk); #2;
      abort[d] = 1'b1;
      @(posedge clk); #2;
      abort[d] = 1'b0;
      send(d, B_ABC, 1'b1, 1'b1);
      drain(d);
      send(d, B_M2B, 1'b0, 1'b1);
      drain(d);
`ifdef SHA224_EN
      mode_224[d] = 1'b1;
      send(d, B_ABC, 1'b1, 1'b1);
      drain(d);
      mode_224[d] = 1'b0;
`endif
   endtask

   task automatic random_run(input int d);
      logic [511:0] dat;
      for (int k = 0; k < 1500; k++) begin
         for (int i = 0; i < 16; i++) dat[32*i +: 32] = $urandom();
         blk_data[d]  = dat;
         blk_valid[d] = ($urandom_range(0, 3) != 0);
         blk_first[d] = ($urandom_range(0, 3) == 0);
         blk_last[d]  = ($urandom_range(0, 2) == 0);
         abort[d]     = ($urandom_range(0, 40) == 0);
`ifdef SHA224_EN
         mode_224[d]  = ($urandom_range(0, 1) == 0);
`endif
         @(posedge clk); #2;
      end
      abort[d] = 1'b0;
      drain(d);
   endtask

   initial begin
      for (int d = 0; d < ND; d++) begin
         blk_valid[d] = 1'b0; blk_data[d] = '0; blk_first[d] = 1'b0; blk_last[d] = 1'b0;
         abort[d] = 1'b0; mode_224[d] = 1'b0; tmo[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #2;

      fork
         directed(0);
         directed(1);
      join

      fork
         send(0, B_ABC, 1'b1, 1'b1);
         send(1, B_ABC, 1'b1, 1'b1);
      join
      blk_valid[0] = 1'b0;
      blk_valid[1] = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      fork
         begin send(0, B_ABC, 1'b1, 1'b1); drain(0); end
         begin send(1, B_ABC, 1'b1, 1'b1); drain(1); end
      join

      fork
         random_run(0);
         random_run(1);
      join

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
